// File: rtl/rand_pkg.sv
// rand_pkg -- shared constants and FSM state type for the rand_range block.
//   RND_W          : width of the raw random word, the limit and the result
//   MAX_TRIES      : consecutive rejections before the fold-back fallback
//   PREFETCH_DEPTH : result FIFO depth (used only with RAND_RANGE_PREFETCH_EN)
package rand_pkg;
  localparam int RND_W          = 10;
  localparam int MAX_TRIES      = 16;
  localparam int PREFETCH_DEPTH = 4;
  localparam int TRY_W          = $clog2(MAX_TRIES);
  localparam int PTR_W          = $clog2(PREFETCH_DEPTH);
  localparam int CNT_W          = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/range_mask.sv
// range_mask -- combinational rejection-sampling mask.
// Produces the smallest all-ones value 2^k-1 that is >= n-1, so that masking a
// random word gives a candidate below 2n. n=0 and n=1 both give mask 0.
// Ports:
//   n    : in,  RND_W bits, exclusive range bound
//   mask : out, RND_W bits, all-ones mask covering n-1
module range_mask
  import rand_pkg::*;
(
  input  logic [RND_W-1:0] n,
  output logic [RND_W-1:0] mask
);

  logic [RND_W-1:0] top_s;

  // Smear the highest set bit of n-1 into every lower position.
  always_comb begin
    top_s = (n == {RND_W{1'b0}}) ? {RND_W{1'b0}} : (n - RND_W'(1));
    mask  = top_s;
    for (int i = 1; i < RND_W; i++) begin
      mask = mask | (top_s >> i);
    end
  end

endmodule

// File: rtl/rand_range.sv
// rand_range -- maps a raw PRNG word onto the range [0, Limit) by masked
// rejection sampling. After MAX_TRIES consecutive rejections the candidate is
// folded back (cand - limit), bounding latency to 17 cycles.
// Optional feature macro: RAND_RANGE_PREFETCH_EN adds a PREFETCH_DEPTH-entry
// result FIFO that is filled while idle for the last latched limit, so a
// repeat request with the same limit answers in one cycle.
// Ports:
//   Clk   : in,  clock, rising edge
//   Reset : in,  synchronous active-high reset
//   Rnd   : in,  10-bit raw random word, fresh each cycle
//   Limit : in,  10-bit exclusive upper bound N
//   Req   : in,  request strobe (ignored while Busy)
//   Value : out, 10-bit result, held until the next result
//   Valid : out, one-cycle pulse marking a new Value
//   Busy  : out, high while a request is in progress
module rand_range
  import rand_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [RND_W-1:0] Rnd,
  input  logic [RND_W-1:0] Limit,
  input  logic             Req,
  output logic [RND_W-1:0] Value,
  output logic             Valid,
  output logic             Busy
);

  state_t           state, state_nxt;
  logic [TRY_W-1:0] try_q, try_nxt;
  logic [RND_W-1:0] lim_q, lim_nxt;
  logic [RND_W-1:0] mask_q, mask_nxt;
  logic [RND_W-1:0] value_nxt;
  logic [RND_W-1:0] mask_s, cand_s, result_s;
  logic             hit_s, take_s;

  range_mask u_range_mask (
    .n    (Limit),
    .mask (mask_s)
  );

  // Candidate evaluation shared by the request path and the prefetch filler.
  // A zero limit accepts the (necessarily zero) candidate immediately.
  always_comb begin
    cand_s   = Rnd & mask_q;
    hit_s    = (cand_s < lim_q) || (lim_q == {RND_W{1'b0}});
    take_s   = hit_s || (try_q == TRY_W'(MAX_TRIES - 1));
    result_s = hit_s ? cand_s : (cand_s - lim_q);
  end

`ifdef RAND_RANGE_PREFETCH_EN
  logic [RND_W-1:0] fifo_mem [PREFETCH_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             armed_q, armed_nxt;
  logic             push_s, pop_s, flush_s;
`endif

  // Next-state, counter and result selection.
  always_comb begin
    state_nxt = state;
    try_nxt   = try_q;
    lim_nxt   = lim_q;
    mask_nxt  = mask_q;
    value_nxt = Value;
`ifdef RAND_RANGE_PREFETCH_EN
    armed_nxt = armed_q;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    flush_s   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (Req) begin
          try_nxt = {TRY_W{1'b0}};
`ifdef RAND_RANGE_PREFETCH_EN
          if (armed_q && (Limit == lim_q) && (fifo_cnt != {CNT_W{1'b0}})) begin
            pop_s     = 1'b1;
            value_nxt = fifo_mem[rd_ptr];
            state_nxt = DONE;
          end else begin
            // Stored results belong to the old limit; drop them on a change.
            flush_s   = (Limit != lim_q);
            armed_nxt = 1'b1;
            lim_nxt   = Limit;
            mask_nxt  = mask_s;
            state_nxt = SAMPLE;
          end
`else
          lim_nxt   = Limit;
          mask_nxt  = mask_s;
          state_nxt = SAMPLE;
`endif
        end else begin
`ifdef RAND_RANGE_PREFETCH_EN
          // Background fill for the last latched limit while nobody asks.
          if (armed_q && (fifo_cnt != CNT_W'(PREFETCH_DEPTH))) begin
            if (take_s) begin
              push_s  = 1'b1;
              try_nxt = {TRY_W{1'b0}};
            end else begin
              try_nxt = try_q + TRY_W'(1);
            end
          end else begin
            try_nxt = try_q;
          end
`else
          state_nxt = IDLE;
`endif
        end
      end
      SAMPLE: begin
        if (take_s) begin
          value_nxt = result_s;
          try_nxt   = {TRY_W{1'b0}};
          state_nxt = DONE;
        end else begin
          try_nxt = try_q + TRY_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched request parameters and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      try_q  <= {TRY_W{1'b0}};
      lim_q  <= {RND_W{1'b0}};
      mask_q <= {RND_W{1'b0}};
      Value  <= {RND_W{1'b0}};
      Valid  <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      try_q  <= try_nxt;
      lim_q  <= lim_nxt;
      mask_q <= mask_nxt;
      Value  <= value_nxt;
      Valid  <= (state_nxt == DONE);
      Busy   <= (state_nxt != IDLE);
    end
  end

`ifdef RAND_RANGE_PREFETCH_EN
  // Prefetch FIFO; push and pop never coincide since both are decided in IDLE.
  always_ff @(posedge Clk) begin
    if (Reset || flush_s) begin
      wr_ptr   <= {PTR_W{1'b0}};
      rd_ptr   <= {PTR_W{1'b0}};
      fifo_cnt <= {CNT_W{1'b0}};
      armed_q  <= Reset ? 1'b0 : armed_nxt;
    end else begin
      armed_q <= armed_nxt;
      if (push_s) begin
        fifo_mem[wr_ptr] <= result_s;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop_s) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      fifo_cnt <= fifo_cnt + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end
`endif

endmodule

// File: tb/tb_rand_range.sv
// tb_rand_range -- self-checking bench for rand_range: directed scenarios with
// literal expectations plus randomized traffic compared every cycle against a
// behavioural model of the sampling rules. Honours RAND_RANGE_PREFETCH_EN.
module tb_rand_range;

  logic       Clk;
  logic       Reset;
  logic [9:0] Rnd;
  logic [9:0] Limit;
  logic       Req;
  logic [9:0] Value;
  logic       Valid;
  logic       Busy;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  hold_rnd = 1'b0;

  rand_range dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Rnd   (Rnd),
    .Limit (Limit),
    .Req   (Req),
    .Value (Value),
    .Valid (Valid),
    .Busy  (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_live = 1'b0;
  bit         m_valid, m_busy, m_flight, m_armed;
  logic [9:0] m_value, m_lim, m_mask;
  int         m_tries;
  int         m_vcnt = 0;
  logic [9:0] m_q[$];

  // Smallest 2^k-1 that is >= n-1 (0 for n = 0 or 1).
  function automatic logic [9:0] mask_of(input int unsigned n);
    int unsigned m = 0;
    while (m + 1 < n) m = m * 2 + 1;
    return 10'(m);
  endfunction

  always @(posedge Clk) begin : model
    logic [9:0] cand;
    if (Reset) begin
      m_live = 1'b1; m_value = 10'd0; m_valid = 1'b0; m_busy = 1'b0;
      m_flight = 1'b0; m_tries = 0; m_lim = 10'd0; m_mask = 10'd0;
      m_armed = 1'b0; m_q.delete();
    end else if (m_live) begin
      cand = Rnd & m_mask;
      if (m_valid) begin
        // The pulse cycle ends the request; a Req here is ignored.
        m_valid = 1'b0; m_busy = 1'b0;
      end else if (m_flight) begin
        if (cand < m_lim || m_lim == 10'd0) begin
          m_value = cand; m_valid = 1'b1; m_flight = 1'b0; m_vcnt++;
        end else if (m_tries == 15) begin
          m_value = cand - m_lim; m_valid = 1'b1; m_flight = 1'b0; m_vcnt++;
        end else begin
          m_tries++;
        end
      end else if (Req) begin
        m_tries = 0;
        if (m_armed && Limit == m_lim && m_q.size() > 0) begin
          m_value = m_q.pop_front(); m_valid = 1'b1; m_busy = 1'b1; m_vcnt++;
        end else begin
          if (Limit != m_lim) m_q.delete();
          m_lim = Limit; m_mask = mask_of(Limit);
          m_flight = 1'b1; m_busy = 1'b1; m_armed = 1'b1;
        end
      end else begin
`ifdef RAND_RANGE_PREFETCH_EN
        if (m_armed && m_q.size() < 4) begin
          if (cand < m_lim || m_lim == 10'd0) begin
            m_q.push_back(cand); m_tries = 0;
          end else if (m_tries == 15) begin
            m_q.push_back(cand - m_lim); m_tries = 0;
          end else begin
            m_tries++;
          end
        end
`endif
      end
    end
  end

  // Per-cycle comparison, half a period away from the active edge.
  always @(negedge Clk) begin
    if (m_live) begin
      check("model_value", 32'(Value), 32'(m_value));
      check("model_valid", 32'(Valid), 32'(m_valid));
      check("model_busy",  32'(Busy),  32'(m_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge Clk);
    #2;
    if (!hold_rnd) Rnd = 10'($urandom);
  endtask

  // Issue one request; report cycles from the Req edge to Valid (20 = timeout).
  task automatic do_req(input logic [9:0] lim, input logic [9:0] rnd, input bit hold,
                        output int lat, output logic [9:0] val);
    hold_rnd = hold;
    if (hold) Rnd = rnd;
    Limit = lim;
    Req = 1'b1;
    cycle();
    Req = 1'b0;
    lat = 1;
    while (!Valid && lat < 20) begin
      cycle();
      lat++;
    end
    val = Value;
    cycle();
  endtask

  initial begin
    int lat;
    logic [9:0] val;
    int dut_cnt, model_start, last_v, min_gap;

    Reset = 1'b1; Req = 1'b0; Limit = 10'd0; Rnd = 10'd0;
    cycle(); cycle();
    check("reset_value", 32'(Value), 32'd0);
    check("reset_valid", 32'(Valid), 32'd0);
    check("reset_busy",  32'(Busy),  32'd0);
    Reset = 1'b0;
    cycle();

    // Limit 8, Rnd 0x0F5 -> 0xF5 & 7 = 5, accepted first try.
    do_req(10'd8, 10'h0F5, 1'b1, lat, val);
    check("lim8_latency", 32'(lat), 32'd2);
    check("lim8_value",   32'(val), 32'd5);

    // Limit 5, Rnd 7 always rejected -> fold-back 7-5 = 2 after 16 tries.
    do_req(10'd5, 10'h007, 1'b1, lat, val);
    check("fold_latency", 32'(lat), 32'd17);
    check("fold_value",   32'(val), 32'd2);

    // Reset in the third SAMPLE cycle aborts the request.
    hold_rnd = 1'b1; Rnd = 10'h007; Limit = 10'd5; Req = 1'b1;
    cycle();
    Req = 1'b0;
    cycle(); cycle();
    check("abort_busy_before", 32'(Busy), 32'd1);
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    check("abort_value", 32'(Value), 32'd0);
    check("abort_valid", 32'(Valid), 32'd0);
    check("abort_busy",  32'(Busy),  32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("abort_no_valid", 32'(Valid), 32'd0);
    end
    do_req(10'd8, 10'h0F5, 1'b1, lat, val);
    check("after_abort_latency", 32'(lat), 32'd2);
    check("after_abort_value",   32'(val), 32'd5);

    // Degenerate limits.
    do_req(10'd0, 10'h3FF, 1'b1, lat, val);
    check("lim0_latency", 32'(lat), 32'd2);
    check("lim0_value",   32'(val), 32'd0);
    do_req(10'd1, 10'h000, 1'b0, lat, val);
    check("lim1_latency", 32'(lat), 32'd2);
    check("lim1_value",   32'(val), 32'd0);

    // Req held high: every request yields exactly one pulse.
    hold_rnd = 1'b0;
    Limit = 10'($urandom_range(1, 1023));
    Req = 1'b1;
    dut_cnt = 0; last_v = -100; min_gap = 1000;
    model_start = m_vcnt;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (Valid) begin
        dut_cnt++;
        if (i - last_v < min_gap) min_gap = i - last_v;
        last_v = i;
      end
    end
    Req = 1'b0;
    for (int i = 0; i < 20 && Busy; i++) cycle();
    check("hold_drained", 32'(Busy), 32'd0);
    check("hold_count", 32'(dut_cnt), 32'(m_vcnt - model_start));
    check("hold_some", 32'(dut_cnt > 0), 32'd1);
`ifdef RAND_RANGE_PREFETCH_EN
    check("hold_gap", 32'(min_gap >= 2), 32'd1);
`else
    check("hold_gap", 32'(min_gap >= 3), 32'd1);
`endif

`ifdef RAND_RANGE_PREFETCH_EN
    // Prefetch: latch limit 100, let the FIFO fill, then drain it quickly.
    do_req(10'd100, 10'h000, 1'b0, lat, val);
    check("pf_first_seen", 32'(lat < 20), 32'd1);
    check("pf_first_range", 32'(val < 10'd100), 32'd1);
    for (int i = 0; i < 60; i++) cycle();
    for (int k = 0; k < 4; k++) begin
      do_req(10'd100, 10'h000, 1'b0, lat, val);
      check("pf_fast_latency", 32'(lat), 32'd1);
      check("pf_fast_range", 32'(val < 10'd100), 32'd1);
    end
    do_req(10'd10, 10'h003, 1'b1, lat, val);
    check("pf_flush_latency", 32'(lat), 32'd2);
    check("pf_flush_value",   32'(val), 32'd3);
`endif

    // Randomized traffic, including limit changes in flight and resets.
    hold_rnd = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      Req = ($urandom_range(0, 2) == 0);
      Reset = ($urandom_range(0, 96) == 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0:       Limit = 10'd0;
          1:       Limit = 10'd1;
          2:       Limit = 10'd512;
          3:       Limit = 10'd513;
          4:       Limit = 10'($urandom_range(2, 9));
          default: Limit = 10'($urandom);
        endcase
      end
      cycle();
    end
    Reset = 1'b0; Req = 1'b0;
    cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
